// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared encodings for the RISC-V pipeline controller: opcodes, ALU operations,
// write-back selects and the per-instruction decode summary.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REGIMM = 7'b0010011;
  localparam logic [6:0] OP_REGREG = 7'b0110011;

  localparam logic [31:0] INST_BUBBLE = '0;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_AND      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SRL      = 4'd3,
    ALU_OR       = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_OUT_ONE  = 4'd6,
    ALU_OUT_ZERO = 4'd7,
    ALU_SRA      = 4'd8,
    ALU_LUI      = 4'd9,
    ALU_SUB      = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
    logic is_load;
  } inst_info_t;

  // SUB only exists in register-register form; shifts pick arithmetic from bit 30.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic [6:0] f7,
                                       input logic is_imm, input logic lt);
    alu_op_t op;
    case (f3)
      3'b000:  op = (!is_imm && f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010,
      3'b011:  op = lt ? ALU_OUT_ONE : ALU_OUT_ZERO;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_pipe_ctrl_if.sv
// Control bus between the pipeline controller and the datapath.
interface rv_pipe_ctrl_if #(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned FW = $clog2(MEM_STAGES + 2);

  logic [31:0]    inst_i;
  logic           inst_valid_i;
  logic           br_eq_i;
  logic           br_lt_i;
  logic           br_un_o;
  logic           stall_o;
  logic           flush_o;
  logic [FW-1:0]  fwd_a_o;
  logic [FW-1:0]  fwd_b_o;
  logic           a_sel_o;
  logic           b_sel_o;
  logic [3:0]     alu_op_o;
  logic           pc_sel_o;
  logic           mem_we_o;
  logic [1:0]     wb_sel_o;
  logic           reg_w_en_o;
  logic [4:0]     wb_rd_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output inst_i, inst_valid_i, br_eq_i, br_lt_i,
    input  br_un_o, stall_o, flush_o, fwd_a_o, fwd_b_o, a_sel_o, b_sel_o,
           alu_op_o, pc_sel_o, mem_we_o, wb_sel_o, reg_w_en_o, wb_rd_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  inst_i, inst_valid_i, br_eq_i, br_lt_i,
    output br_un_o, stall_o, flush_o, fwd_a_o, fwd_b_o, a_sel_o, b_sel_o,
           alu_op_o, pc_sel_o, mem_we_o, wb_sel_o, reg_w_en_o, wb_rd_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/rv_pipe_ctrl_inst_decode.sv
// Register-usage summary of one instruction; bubbles (opcode 0) assert nothing.
module rv_inst_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output inst_info_t info
);
  logic rd_nz;
  assign rd_nz = |rd;

  always_comb begin
    info = '0;
    case (opcode)
      OP_REGREG: begin
        info.writes_rd = rd_nz;
        info.uses_rs1  = 1'b1;
        info.uses_rs2  = 1'b1;
      end
      OP_REGIMM, OP_JALR: begin
        info.writes_rd = rd_nz;
        info.uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        info.writes_rd = rd_nz;
        info.uses_rs1  = 1'b1;
        info.is_load   = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        info.uses_rs1  = 1'b1;
        info.uses_rs2  = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        info.writes_rd = rd_nz;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipeline controller: EX, MEM_STAGES memory stages and WB; forwarding,
// load-use stall, branch flush, datapath selects and event counters.
module rv_pipe_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  rv_pipe_ctrl_if.slave bus
);
  // Index 0 = EX, 1..MEM_STAGES = MEM0.., MEM_STAGES+1 = WB; that index is the forward code.
  localparam int unsigned NST    = MEM_STAGES + 2;
  localparam int unsigned WB_IDX = MEM_STAGES + 1;
  localparam int unsigned FW     = $clog2(MEM_STAGES + 2);

  logic [31:0]      stage_q [NST];
  logic [11:0]      word_lo [NST+1];
  inst_info_t       info    [NST+1];

  logic             stall, flush, hazard, pc_sel, br_un, a_sel, b_sel;
  logic [2:0]       ex_f3;
  logic [6:0]       ex_f7;
  alu_op_t          alu_op;
  wb_sel_t          wb_sel;
  logic [FW-1:0]    fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Last decoder instance looks at the instruction still in decode.
  always_comb begin
    for (int unsigned k = 0; k < NST; k++) word_lo[k] = stage_q[k][11:0];
    word_lo[NST] = bus.inst_i[11:0];
  end

  for (genvar g = 0; g <= int'(NST); g++) begin : g_dec
    rv_inst_decode u_dec (
      .opcode (word_lo[g][6:0]),
      .rd     (word_lo[g][11:7]),
      .info   (info[g])
    );
  end

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int unsigned k = NST - 1; k > 0; k--) begin
      if (info[0].uses_rs1 && info[k].writes_rd && stage_q[k][11:7] == stage_q[0][19:15])
        fwd_a = FW'(k);
      if (info[0].uses_rs2 && info[k].writes_rd && stage_q[k][11:7] == stage_q[0][24:20])
        fwd_b = FW'(k);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < MEM_STAGES; k++) begin
      if (info[k].is_load && info[k].writes_rd &&
          ((info[NST].uses_rs1 && stage_q[k][11:7] == bus.inst_i[19:15]) ||
           (info[NST].uses_rs2 && stage_q[k][11:7] == bus.inst_i[24:20])))
        hazard = 1'b1;
    end
  end

  assign flush = pc_sel;
  assign stall = bus.inst_valid_i && hazard && !pc_sel;

  assign ex_f3 = stage_q[0][14:12];
  assign ex_f7 = stage_q[0][31:25];

  always_comb begin
    pc_sel = 1'b0;
    br_un  = 1'b0;
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    alu_op = ALU_OUT_ZERO;
    case (stage_q[0][6:0])
      OP_LUI: begin
        b_sel  = 1'b1;
        alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        a_sel  = 1'b1;
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
      end
      OP_JAL: begin
        a_sel  = 1'b1;
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
        pc_sel = 1'b1;
      end
      OP_JALR: begin
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
        pc_sel = 1'b1;
      end
      OP_BRANCH: begin
        a_sel  = 1'b1;
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
        br_un  = ex_f3[2] && ex_f3[1];
        case (ex_f3)
          3'b000:  pc_sel = bus.br_eq_i;
          3'b001:  pc_sel = !bus.br_eq_i;
          3'b100,
          3'b110:  pc_sel = bus.br_lt_i;
          3'b101,
          3'b111:  pc_sel = !bus.br_lt_i;
          default: pc_sel = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        b_sel  = 1'b1;
        alu_op = ALU_ADD;
      end
      OP_REGIMM: begin
        b_sel  = 1'b1;
        br_un  = (ex_f3 == 3'b011);
        alu_op = arith_op(ex_f3, ex_f7, 1'b1, bus.br_lt_i);
      end
      OP_REGREG: begin
        br_un  = (ex_f3 == 3'b011);
        alu_op = arith_op(ex_f3, ex_f7, 1'b0, bus.br_lt_i);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (stage_q[WB_IDX][6:0])
      OP_LOAD:          wb_sel = WB_MEM;
      OP_JAL, OP_JALR:  wb_sel = WB_PC4;
      default:          wb_sel = WB_ALU;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NST; k++) stage_q[k] <= INST_BUBBLE;
    end else begin
      stage_q[0] <= (bus.inst_valid_i && !stall && !flush) ? bus.inst_i : INST_BUBBLE;
      for (int unsigned k = 1; k < NST; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.br_un_o     = br_un;
  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.fwd_a_o     = fwd_a;
  assign bus.fwd_b_o     = fwd_b;
  assign bus.a_sel_o     = a_sel;
  assign bus.b_sel_o     = b_sel;
  assign bus.alu_op_o    = alu_op;
  assign bus.pc_sel_o    = pc_sel;
  assign bus.mem_we_o    = (stage_q[1][6:0] == OP_STORE);
  assign bus.wb_sel_o    = wb_sel;
  assign bus.reg_w_en_o  = info[WB_IDX].writes_rd;
  assign bus.wb_rd_o     = stage_q[WB_IDX][11:7];
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;

endmodule
